// File: rtl/riscv_ctrl_pkg.sv
// Purpose: shared encodings for the multi-cycle RV32I controller (opcodes, functs, mux selects, FSM states).
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Ports: none (package).
package riscv_ctrl_pkg;

  // Major opcodes, instr[6:0]
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;

  // funct3 values, instr[14:12]
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_WORD = 3'd2;
  localparam logic [2:0] F3_JALR = 3'd0;

  // funct7 values, instr[31:25]
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  // ALU function codes; widened or narrowed to ALU_OP_W at the top.
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Result mux
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  // ALU operand muxes
  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_JAL,
    S_JALR1,
    S_JALR2,
    S_BRANCH,
    S_LUI_WB,
    S_TRAP
  } state_e;

endpackage

// File: rtl/alu_decoder.sv
// Purpose: decodes opcode/funct3/funct7 into the ALU function and an instruction-legal flag.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the IR fields.
// Ports: opc/f3/f7 in (IR fields); alu_op out (ALU_OP_W), legal out (1 = supported encoding).
module alu_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 3,
  parameter int EN_JALR  = 1
) (
  input  logic [6:0]          opc,
  input  logic [2:0]          f3,
  input  logic [6:0]          f7,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                legal
);

  logic [2:0] alu_code;

  always_comb begin
    alu_code = ALU_ADD;
    legal    = 1'b0;
    unique case (opc)
      OPC_LOAD, OPC_STORE: legal = (f3 == F3_WORD);
      OPC_OP: begin
        // Only the funct7=0x20 form of funct3=0 (SUB) uses the alternate funct7.
        unique case (f3)
          F3_ADD: begin
            if (f7 == F7_BASE) begin
              legal = 1'b1;
            end else if (f7 == F7_ALT) begin
              legal    = 1'b1;
              alu_code = ALU_SUB;
            end
          end
          F3_SLT: begin legal = (f7 == F7_BASE); alu_code = ALU_SLT; end
          F3_OR:  begin legal = (f7 == F7_BASE); alu_code = ALU_OR;  end
          F3_AND: begin legal = (f7 == F7_BASE); alu_code = ALU_AND; end
          default: legal = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        // Immediate forms ignore funct7 (it is part of the immediate).
        unique case (f3)
          F3_ADD: begin legal = 1'b1; alu_code = ALU_ADD; end
          F3_SLT: begin legal = 1'b1; alu_code = ALU_SLT; end
          F3_OR:  begin legal = 1'b1; alu_code = ALU_OR;  end
          F3_AND: begin legal = 1'b1; alu_code = ALU_AND; end
          default: legal = 1'b0;
        endcase
      end
      OPC_JAL, OPC_LUI: legal = 1'b1;
      OPC_JALR:   legal = (EN_JALR != 0) && (f3 == F3_JALR);
      OPC_BRANCH: begin
        legal    = (f3 == F3_BEQ) || (f3 == F3_BNE);
        alu_code = ALU_SUB;
      end
      default: legal = 1'b0;
    endcase
  end

  assign alu_op = ALU_OP_W'(alu_code);

endmodule

// File: rtl/multi_cycle_controller.sv
// Purpose: multi-cycle RV32I control FSM driving datapath muxes/enables for a shared instruction/data memory.
// Latency: 3-5 cycles per instruction plus memory wait cycles; instr_done pulses in the retiring cycle.
// Backpressure: FETCH, MEM_RD and MEM_WR stall on mem_ready (ignored when MEM_WAIT=0); TRAP halts until reset.
// Ports: clk/rst_n; instr, zero, mem_ready in; pc_write, ir_write, adr_src, mem_write, reg_write,
//        result_src, alu_src_a, alu_src_b, imm_src, alu_op, illegal, instr_done out.
module multi_cycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 3,
  parameter int EN_JALR  = 1,
  parameter int MEM_WAIT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                adr_src,
  output logic                mem_write,
  output logic                reg_write,
  output logic [1:0]          result_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [2:0]          imm_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal,
  output logic                instr_done
);

  localparam logic [ALU_OP_W-1:0] OP_ADD = ALU_OP_W'(ALU_ADD);
  localparam logic [ALU_OP_W-1:0] OP_SUB = ALU_OP_W'(ALU_SUB);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  logic [6:0]          opc;
  logic [2:0]          f3;
  logic [6:0]          f7;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                dec_legal;
  logic                mem_rdy;

  // Raw enables before reset masking.
  logic pc_write_c, ir_write_c, mem_write_c, reg_write_c, done_c;

  // Register/immediate fields belong to the datapath, not the controller.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  assign mem_rdy = (MEM_WAIT != 0) ? mem_ready : 1'b1;

  alu_decoder #(
    .ALU_OP_W (ALU_OP_W),
    .EN_JALR  (EN_JALR)
  ) u_alu_decoder (
    .opc    (opc),
    .f3     (f3),
    .f7     (f7),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    done_c      = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RS2;
    imm_src     = IMM_I;
    alu_op      = OP_ADD;

    unique case (state_q)
      S_FETCH: begin
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        if (mem_rdy) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch/jump target is precomputed here and parked in ALUOut.
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        imm_src   = (opc == OPC_JAL) ? IMM_J : IMM_B;
        if (!dec_legal) begin
          state_d = S_TRAP;
        end else begin
          unique case (opc)
            OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
            OPC_OP:              state_d = S_EXEC_R;
            OPC_OPIMM:           state_d = S_EXEC_I;
            OPC_JAL:             state_d = S_JAL;
            OPC_JALR:            state_d = S_JALR1;
            OPC_BRANCH:          state_d = S_BRANCH;
            OPC_LUI:             state_d = S_LUI_WB;
            default:             state_d = S_TRAP;
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        imm_src   = (opc == OPC_STORE) ? IMM_S : IMM_I;
        state_d   = (opc == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        adr_src = 1'b1;
        if (mem_rdy) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src  = RES_MEM;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_WR: begin
        // Strobe stays up for the whole access; the store retires on the ready cycle.
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        if (mem_rdy) begin
          done_c  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = dec_alu_op;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = dec_alu_op;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL, S_JALR2: begin
        // PC takes the parked target while the ALU forms OldPC+4 for the link write.
        // Target was captured before rd is written, so jalr with rd==rs1 is safe.
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        pc_write_c = 1'b1;
        state_d    = S_ALU_WB;
      end
      S_JALR1: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_d   = S_JALR2;
      end
      S_BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = OP_SUB;
        pc_write_c = ((f3 == F3_BEQ) && zero) || ((f3 == F3_BNE) && !zero);
        done_c     = 1'b1;
        state_d    = S_FETCH;
      end
      S_LUI_WB: begin
        imm_src     = IMM_U;
        result_src  = RES_IMM;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Reset masks the strobes asynchronously so an in-flight write is dropped at once.
  assign pc_write   = pc_write_c  & rst_n;
  assign ir_write   = ir_write_c  & rst_n;
  assign mem_write  = mem_write_c & rst_n;
  assign reg_write  = reg_write_c & rst_n;
  assign instr_done = done_c      & rst_n;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Purpose: directed scoreboard bench for multi_cycle_controller (EN_JALR=0, MEM_WAIT=1).
// Latency: expected vector per cycle queued at drive time, checked on the following falling edge.
// Backpressure: exercises mem_ready stalls in FETCH, MEM_RD and MEM_WR.
module tb_multi_cycle_controller;

  typedef struct packed {
    logic       pcw;
    logic       irw;
    logic       adr;
    logic       mw;
    logic       rw;
    logic [1:0] rs;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] imm;
    logic [2:0] op;
    logic       ill;
    logic       done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, ir_write, adr_src, mem_write, reg_write;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic [2:0]  imm_src;
  logic [2:0]  alu_op;
  logic        illegal, instr_done;

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t sb_q[$];
  string nm_q[$];

  always #5 clk = ~clk;

  multi_cycle_controller #(
    .ALU_OP_W (3),
    .EN_JALR  (0),
    .MEM_WAIT (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_src    (imm_src),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .instr_done (instr_done)
  );

  // Hand-written per-state output vectors.
  function automatic exp_t mk(input logic pcw, input logic irw, input logic adr, input logic mw,
                              input logic rw, input logic [1:0] rs, input logic [1:0] a,
                              input logic [1:0] b, input logic [2:0] imm, input logic [2:0] op,
                              input logic ill, input logic done);
    mk = '{pcw, irw, adr, mw, rw, rs, a, b, imm, op, ill, done};
  endfunction

  function automatic exp_t e_fetch(input logic mr);  return mk(mr, mr, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'd0, 0, 0); endfunction
  function automatic exp_t e_decode(input logic j);  return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, j ? 3'b011 : 3'b010, 3'd0, 0, 0); endfunction
  function automatic exp_t e_exec_r(input logic [2:0] op); return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, op, 0, 0); endfunction
  function automatic exp_t e_exec_i(input logic [2:0] op); return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, op, 0, 0); endfunction
  function automatic exp_t e_alu_wb();               return mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'd0, 0, 1); endfunction
  function automatic exp_t e_branch(input logic pcw); return mk(pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'd1, 0, 1); endfunction
  function automatic exp_t e_memadr(input logic s);  return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, s ? 3'b001 : 3'b000, 3'd0, 0, 0); endfunction
  function automatic exp_t e_mem_rd();               return mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'd0, 0, 0); endfunction
  function automatic exp_t e_mem_wb();               return mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'd0, 0, 1); endfunction
  function automatic exp_t e_mem_wr(input logic mr); return mk(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'd0, 0, mr); endfunction
  function automatic exp_t e_jal();                  return mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'd0, 0, 0); endfunction
  function automatic exp_t e_lui_wb();               return mk(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b100, 3'd0, 0, 1); endfunction
  function automatic exp_t e_trap();                 return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'd0, 1, 0); endfunction
  // Reset sits in FETCH with all strobes masked and illegal cleared.
  function automatic exp_t e_reset();                return mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'd0, 0, 0); endfunction

  // Drive one cycle's inputs, queue its expectation, advance to just after the next rising edge.
  task automatic cyc(input logic mr, input logic z, input exp_t e, input string nm);
    mem_ready = mr;
    zero      = z;
    sb_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every falling edge with a pending expectation is one comparison.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t  e;
      exp_t  got;
      string nm;
      e   = sb_q.pop_front();
      nm  = nm_q.pop_front();
      got = '{pc_write, ir_write, adr_src, mem_write, reg_write, result_src,
              alu_src_a, alu_src_b, imm_src, alu_op, illegal, instr_done};
      n_checks++;
      if (got !== e) begin
        n_fails++;
        $display("FAIL %s @%0t: got pcw=%b irw=%b adr=%b mw=%b rw=%b rs=%b a=%b b=%b imm=%b op=%0d ill=%b done=%b, need pcw=%b irw=%b adr=%b mw=%b rw=%b rs=%b a=%b b=%b imm=%b op=%0d ill=%b done=%b",
                 nm, $time, got.pcw, got.irw, got.adr, got.mw, got.rw, got.rs, got.a, got.b, got.imm, got.op, got.ill, got.done,
                 e.pcw, e.irw, e.adr, e.mw, e.rw, e.rs, e.a, e.b, e.imm, e.op, e.ill, e.done);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    instr     = 32'h0000_0000;
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    // Reset with mem_ready high: FETCH would otherwise strobe pc/ir.
    repeat (3) cyc(1, 0, e_reset(), "reset");
    rst_n = 1'b1;

    // add x3,x1,x2
    instr = 32'h0020_81B3;
    cyc(1, 0, e_fetch(1), "add_fetch");
    cyc(1, 0, e_decode(0), "add_decode");
    cyc(1, 0, e_exec_r(3'd0), "add_exec");
    cyc(1, 0, e_alu_wb(), "add_wb");

    // sub x3,x1,x2
    instr = 32'h4020_81B3;
    cyc(1, 0, e_fetch(1), "sub_fetch");
    cyc(1, 0, e_decode(0), "sub_decode");
    cyc(1, 0, e_exec_r(3'd1), "sub_exec");
    cyc(1, 0, e_alu_wb(), "sub_wb");

    // and x3,x1,x2
    instr = 32'h0020_F1B3;
    cyc(1, 0, e_fetch(1), "and_fetch");
    cyc(1, 0, e_decode(0), "and_decode");
    cyc(1, 0, e_exec_r(3'd2), "and_exec");
    cyc(1, 0, e_alu_wb(), "and_wb");

    // slti x3,x1,5
    instr = 32'h0050_A193;
    cyc(1, 0, e_fetch(1), "slti_fetch");
    cyc(1, 0, e_decode(0), "slti_decode");
    cyc(1, 0, e_exec_i(3'd4), "slti_exec");
    cyc(1, 0, e_alu_wb(), "slti_wb");

    // beq taken, then not taken
    instr = 32'h0020_8463;
    cyc(1, 0, e_fetch(1), "beq_t_fetch");
    cyc(1, 0, e_decode(0), "beq_t_decode");
    cyc(1, 1, e_branch(1), "beq_taken");
    cyc(1, 0, e_fetch(1), "beq_n_fetch");
    cyc(1, 0, e_decode(0), "beq_n_decode");
    cyc(1, 0, e_branch(0), "beq_not_taken");

    // jal x1,8
    instr = 32'h0080_00EF;
    cyc(1, 0, e_fetch(1), "jal_fetch");
    cyc(1, 0, e_decode(1), "jal_decode");
    cyc(1, 0, e_jal(), "jal_jump");
    cyc(1, 0, e_alu_wb(), "jal_link");

    // lw x5,4(x1) with a stalled fetch and a stalled read
    instr = 32'h0040_A283;
    cyc(0, 0, e_fetch(0), "lw_fetch_wait");
    cyc(1, 0, e_fetch(1), "lw_fetch");
    cyc(1, 0, e_decode(0), "lw_decode");
    cyc(1, 0, e_memadr(0), "lw_memadr");
    cyc(0, 0, e_mem_rd(), "lw_rd_wait");
    cyc(0, 0, e_mem_rd(), "lw_rd_wait");
    cyc(1, 0, e_mem_rd(), "lw_rd");
    cyc(1, 0, e_mem_wb(), "lw_wb");

    // sw with three wait cycles: strobe held four cycles, retire on the ready cycle
    instr = 32'h0020_A223;
    cyc(1, 0, e_fetch(1), "sw_fetch");
    cyc(1, 0, e_decode(0), "sw_decode");
    cyc(1, 0, e_memadr(1), "sw_memadr");
    repeat (3) cyc(0, 0, e_mem_wr(0), "sw_wr_wait");
    cyc(1, 0, e_mem_wr(1), "sw_wr_ready");

    // lui x5,0x12345 -- its fetch is the cycle right after the store completes
    instr = 32'h1234_52B7;
    cyc(1, 0, e_fetch(1), "lui_fetch");
    cyc(1, 0, e_decode(0), "lui_decode");
    cyc(1, 0, e_lui_wb(), "lui_wb");

    // All-ones word traps; flag sticky, mem_ready ignored
    instr = 32'hFFFF_FFFF;
    cyc(1, 0, e_fetch(1), "ill_fetch");
    cyc(1, 0, e_decode(0), "ill_decode");
    for (int i = 0; i < 20; i++) cyc(i[0], i[1], e_trap(), "ill_trap");

    rst_n = 1'b0;
    cyc(1, 0, e_reset(), "trap_reset");
    cyc(1, 0, e_reset(), "trap_reset");
    rst_n = 1'b1;

    // jalr is illegal in this configuration
    instr = 32'h0000_80E7;
    cyc(1, 0, e_fetch(1), "jalr_fetch");
    cyc(1, 0, e_decode(0), "jalr_decode");
    for (int i = 0; i < 3; i++) cyc(1, 0, e_trap(), "jalr_trap");

    rst_n = 1'b0;
    cyc(1, 0, e_reset(), "jalr_reset");
    rst_n = 1'b1;

    // Reset arriving mid-store: strobe drops within the same cycle
    instr = 32'h0020_A223;
    cyc(1, 0, e_fetch(1), "sw2_fetch");
    cyc(1, 0, e_decode(0), "sw2_decode");
    cyc(1, 0, e_memadr(1), "sw2_memadr");
    cyc(0, 0, e_mem_wr(0), "sw2_wr_wait");
    rst_n = 1'b0;
    cyc(0, 0, e_reset(), "sw2_reset_mid_wr");
    cyc(1, 0, e_reset(), "sw2_reset_hold");
    rst_n = 1'b1;
    cyc(0, 0, e_fetch(0), "post_reset_fetch_wait");
    cyc(1, 0, e_fetch(1), "post_reset_fetch");
    cyc(1, 0, e_decode(0), "post_reset_decode");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fails++;
      $display("FAIL scoreboard_drain: %0d entries left, need 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
